fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter sequencer and fetch-stage register for the processor's instruction memory. Owns the PC, drives it into the memory each cycle, and registers the returned instruction into the decode stage. Resolves the next PC from three sources: execute-stage branch redirect, fetch-time J decode, or sequential increment. Detects the END word and out-of-range PCs and halts fetch; also handles stalls and branch-shadow squashing.

Parameters:
MEM_DEPTH, 20, number of instruction words; a PC >= MEM_DEPTH is out of range.
FLUSH_CYCLES, 1, number of fetched words squashed to NOP after a branch redirect (legal range 0..7).
NOP_WORD, 32'hF800_0000, instruction word issued when not issuing a real instruction.
END_WORD, 32'hFFFF_FFFF, end-of-program marker.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins fetch from PC 0.
stall  in  1  downstream hazard; freezes PC and the fetch register.
branch_taken  in  1  execute-stage redirect request.
branch_target  in  32  redirect PC; valid while branch_taken=1.
instr_in  in  32  memory word at pc_out (combinational read).
pc_out  out  32  current fetch PC, to memory address.
instr_out  out  32  registered instruction to decode.
pc_of_instr  out  32  PC of instr_out.
valid_out  out  1  instr_out is a real, non-squashed instruction.
halted  out  1  fetch stopped (END word or fault).
fault  out  1  halt was caused by an out-of-range PC.
issue_count  out  32  see Optional Feature.

Behaviour:
- Reset (async, any state): state=IDLE; pc_out=0, instr_out=NOP_WORD, pc_of_instr=0, valid_out=0, halted=0, fault=0, squash counter=0, issue_count=0.
- States: IDLE, RUN, HALT.
- IDLE: outputs hold their reset values. If start=1, go to RUN at the next edge; the first fetch is at PC 0. Every other input is ignored in IDLE.
- RUN: each edge evaluates the following, in priority order:
  1. branch_taken=1 (wins over stall and over J): pc_out<=branch_target; instr_out<=NOP_WORD; valid_out<=0; squash counter<=FLUSH_CYCLES.
  2. stall=1: pc_out, instr_out, pc_of_instr, valid_out and the squash counter all hold.
  3. pc_out>=MEM_DEPTH: go to HALT; halted<=1; fault<=1; instr_out<=NOP_WORD; valid_out<=0.
  4. instr_in==END_WORD: go to HALT; halted<=1; instr_out<=NOP_WORD; valid_out<=0. END is never issued as valid.
  5. Otherwise the word is issued: instr_out<=instr_in; pc_of_instr<=pc_out.
     - If the squash counter is nonzero: valid_out<=0, instr_out<=NOP_WORD, counter decrements.
     - Else valid_out<=1.
     - Next PC: if instr_in[31:27]==5'd16 (J), pc_out<={5'b0, instr_in[26:0]}; otherwise pc_out<=pc_out+1.
     - A J word in the squash shadow does not redirect.
- Latency: a word at pc_out appears on instr_out one edge later.
- pc_out+1 wraps modulo 2^32 with no special handling; the out-of-range check catches any wrap.
- HALT: all outputs frozen, and start, stall and branch_taken are ignored. Only rst leaves HALT.
- Reset asserted mid-RUN or mid-squash clears everything immediately (asynchronously). No partial state survives.

Optional Feature:
FETCH_ISSUE_COUNT_EN
- Defined: issue_count increments by 1 on every edge where valid_out is loaded with 1, and saturates at 32'hFFFF_FFFF. It clears on rst and holds in HALT.
- Undefined: issue_count is tied to 0 and no counter register is built.

Test Plan:
- Program {NOP, ADDI, ADDI, END}; start at cycle 1 → instr_out shows mem[0..2] on cycles 2..4 with valid_out=1 and pc_of_instr=0,1,2. halted=1 from cycle 5 with pc_out frozen at 3. issue_count=3 when the feature is enabled.
- mem[2]=J 18 (32'h8000_0012), MEM_DEPTH=20 → pc_out sequence 0,1,2,18,19; mem[19]=END → halt with fault=0.
- branch_taken=1, target=15 while stall=1 at pc_out=10 → next pc_out=15, instr_out=NOP, valid_out=0. With FLUSH_CYCLES=1, mem[15] is issued with valid_out=0 and mem[16] with valid_out=1.
- stall held 3 cycles at pc_out=5 → pc_out, instr_out and valid_out are unchanged for exactly 3 edges, then resume at 6.
- J to 25 with MEM_DEPTH=20 → the edge after the jump sets halted=1 and fault=1; pc_out stays 25.
- rst asserted mid-RUN between edges → outputs return to reset values immediately. A start pulse after rst deasserts refetches from PC 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer and fetch-stage register.
// Owns the PC, registers the instruction returned by memory and resolves the
// next PC from a branch redirect, a J decoded at fetch, or PC+1. It halts on
// the END word or on an out-of-range PC.
// Optional build macro: FETCH_ISSUE_COUNT_EN adds a saturating count of issued
// (valid) instructions on issue_count. Without it, issue_count is tied to zero.
//
// Handshake: there is no valid/ready pair here. stall is a plain freeze
// request. valid_out qualifies instr_out on every cycle in which it is high.
// The FSM state is kept in state_q so a checker can bind to it.
module fetch_sequencer #(
    parameter int unsigned MEM_DEPTH    = 20,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] NOP_WORD     = 32'hF800_0000,
    parameter logic [31:0] END_WORD     = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_of_instr,
    output logic        valid_out,
    output logic        halted,
    output logic        fault,
    output logic [31:0] issue_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH      = 32'(MEM_DEPTH);
    localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [4:0]  OP_J       = 5'd16;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_instr_q, pc_instr_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [2:0]  squash_q, squash_d;
`ifdef FETCH_ISSUE_COUNT_EN
    logic [31:0] issue_count_q, issue_count_d;
`endif

    // Next-state logic. Every register holds unless the RUN priority chain
    // loads it. A branch redirect beats a stall, and a stall beats halt and issue.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_instr_d = pc_instr_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        squash_d   = squash_q;
`ifdef FETCH_ISSUE_COUNT_EN
        issue_count_d = issue_count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (branch_taken) begin
                    pc_d     = branch_target;
                    instr_d  = NOP_WORD;
                    valid_d  = 1'b0;
                    squash_d = FLUSH_INIT;
                end else if (stall) begin
                    // Freeze the PC, the fetch register and the shadow count.
                end else if (pc_q >= DEPTH) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    fault_d  = 1'b1;
                    instr_d  = NOP_WORD;
                    valid_d  = 1'b0;
                end else if (instr_in == END_WORD) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    instr_d  = NOP_WORD;
                    valid_d  = 1'b0;
                end else begin
                    pc_instr_d = pc_q;
                    if (squash_q != 3'd0) begin
                        // A word in the branch shadow is squashed to a NOP,
                        // and a J in the shadow does not redirect the PC.
                        instr_d  = NOP_WORD;
                        valid_d  = 1'b0;
                        squash_d = squash_q - 3'd1;
                        pc_d     = pc_q + 32'd1;
                    end else begin
                        instr_d = instr_in;
                        valid_d = 1'b1;
                        if (instr_in[31:27] == OP_J) begin
                            pc_d = {5'b0, instr_in[26:0]};
                        end else begin
                            pc_d = pc_q + 32'd1;
                        end
`ifdef FETCH_ISSUE_COUNT_EN
                        if (issue_count_q != 32'hFFFF_FFFF) begin
                            issue_count_d = issue_count_q + 32'd1;
                        end
`endif
                    end
                end
            end
            S_HALT: begin
                // Frozen until the next reset.
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and fetch registers. Reset clears them asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= 32'd0;
            instr_q    <= NOP_WORD;
            pc_instr_q <= 32'd0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            squash_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_instr_q <= pc_instr_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            squash_q   <= squash_d;
        end
    end

`ifdef FETCH_ISSUE_COUNT_EN
    // Saturating count of issued instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count_q <= 32'd0;
        end else begin
            issue_count_q <= issue_count_d;
        end
    end
    assign issue_count = issue_count_q;
`else
    assign issue_count = 32'd0;
`endif

    assign pc_out      = pc_q;
    assign instr_out   = instr_q;
    assign pc_of_instr = pc_instr_q;
    assign valid_out   = valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors with hand-computed expectations for
// fetch_sequencer. The instruction memory is a small array indexed by pc_out.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP  = 32'hF800_0000;
    localparam logic [31:0] ENDW = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [31:0] pc_of_instr;
    logic        valid_out;
    logic        halted;
    logic        fault;
    logic [31:0] issue_count;

    logic [31:0] mem [0:31];

    int n_vec;
    int n_err;

    fetch_sequencer #(
        .MEM_DEPTH   (20),
        .FLUSH_CYCLES(1),
        .NOP_WORD    (32'hF800_0000),
        .END_WORD    (32'hFFFF_FFFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instr_in     (instr_in),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .pc_of_instr  (pc_of_instr),
        .valid_out    (valid_out),
        .halted       (halted),
        .fault        (fault),
        .issue_count  (issue_count)
    );

    assign instr_in = (pc_out < 32'd32) ? mem[pc_out[4:0]] : NOP;

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_ic(input int n);
`ifdef FETCH_ISSUE_COUNT_EN
        return 32'(n);
`else
        return 32'd0 + 32'(n - n);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = NOP;
    endtask

    task automatic do_reset();
        start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Fill 0..16 with distinct non-J words and put END at 17.
    task automatic load_linear();
        clear_mem();
        for (int i = 0; i <= 16; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[17] = ENDW;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'd0;
        clear_mem();
        #2 rst = 1'b1;
        #1;
        check("rst_pc", pc_out, 32'd0);
        check("rst_instr", instr_out, NOP);
        check("rst_pc_of", pc_of_instr, 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_ic", issue_count, 32'd0);

        // Program {NOP, ADDI, ADDI, END}
        mem[0] = NOP; mem[1] = 32'h1000_0005; mem[2] = 32'h1000_0007; mem[3] = ENDW;
        do_reset();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd7;
        step();
        check("idle_ignore_pc", pc_out, 32'd0);
        check("idle_ignore_valid", 32'(valid_out), 32'd0);
        stall = 1'b0; branch_taken = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("entry_pc", pc_out, 32'd0);
        check("entry_valid", 32'(valid_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("prog_instr", instr_out, mem[i]);
            check("prog_valid", 32'(valid_out), 32'd1);
            check("prog_pc_of", pc_of_instr, 32'(i));
            check("prog_pc", pc_out, 32'(i + 1));
        end
        step();
        check("end_halted", 32'(halted), 32'd1);
        check("end_fault", 32'(fault), 32'd0);
        check("end_valid", 32'(valid_out), 32'd0);
        check("end_instr", instr_out, NOP);
        check("end_pc", pc_out, 32'd3);
        check("end_ic", issue_count, exp_ic(3));
        start = 1'b1; branch_taken = 1'b1; branch_target = 32'd9;
        step();
        step();
        start = 1'b0; branch_taken = 1'b0;
        check("halt_frozen_pc", pc_out, 32'd3);
        check("halt_frozen_halted", 32'(halted), 32'd1);
        check("halt_frozen_ic", issue_count, exp_ic(3));

        // J 18, then mem[18], then END at 19.
        clear_mem();
        mem[0] = 32'h1000_0001; mem[1] = 32'h1000_0002; mem[2] = 32'h8000_0012;
        mem[18] = 32'h1000_0012; mem[19] = ENDW;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); check("j_pc1", pc_out, 32'd1);
        step(); check("j_pc2", pc_out, 32'd2);
        step();
        check("j_pc18", pc_out, 32'd18);
        check("j_instr", instr_out, 32'h8000_0012);
        check("j_valid", 32'(valid_out), 32'd1);
        step();
        check("j_pc19", pc_out, 32'd19);
        check("j_pc_of18", pc_of_instr, 32'd18);
        step();
        check("j_end_halted", 32'(halted), 32'd1);
        check("j_end_fault", 32'(fault), 32'd0);
        check("j_end_pc", pc_out, 32'd19);

        // Branch under stall at pc 10, squashed J at 15 does not redirect.
        load_linear();
        mem[15] = 32'h8000_0003;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("br_pre_pc", pc_out, 32'd10);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd15;
        step();
        stall = 1'b0; branch_taken = 1'b0;
        check("br_pc", pc_out, 32'd15);
        check("br_instr", instr_out, NOP);
        check("br_valid", 32'(valid_out), 32'd0);
        step();
        check("sq_valid", 32'(valid_out), 32'd0);
        check("sq_instr", instr_out, NOP);
        check("sq_pc_of", pc_of_instr, 32'd15);
        check("sq_pc", pc_out, 32'd16);
        step();
        check("post_sq_valid", 32'(valid_out), 32'd1);
        check("post_sq_instr", instr_out, 32'h1000_0010);
        check("post_sq_pc_of", pc_of_instr, 32'd16);
        check("post_sq_ic", issue_count, exp_ic(11));

        // Stall held three edges at pc 5, then resume.
        load_linear();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("st_pre_pc", pc_out, 32'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_pc", pc_out, 32'd5);
            check("st_instr", instr_out, 32'h1000_0004);
            check("st_valid", 32'(valid_out), 32'd1);
        end
        stall = 1'b0;
        step();
        check("st_resume_instr", instr_out, 32'h1000_0005);
        check("st_resume_pc", pc_out, 32'd6);

        // Asynchronous reset between edges, then refetch from 0.
        #2 rst = 1'b1;
        #1;
        check("arst_pc", pc_out, 32'd0);
        check("arst_instr", instr_out, NOP);
        check("arst_valid", 32'(valid_out), 32'd0);
        check("arst_ic", issue_count, 32'd0);
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("refetch_instr", instr_out, 32'h1000_0000);
        check("refetch_pc_of", pc_of_instr, 32'd0);
        check("refetch_pc", pc_out, 32'd1);

        // J to 25 lands out of range and faults.
        clear_mem();
        mem[0] = 32'h8000_0019;
        mem[25] = 32'h1000_0019;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("oor_pc", pc_out, 32'd25);
        check("oor_valid_j", 32'(valid_out), 32'd1);
        step();
        check("oor_halted", 32'(halted), 32'd1);
        check("oor_fault", 32'(fault), 32'd1);
        check("oor_pc_hold", pc_out, 32'd25);
        check("oor_valid", 32'(valid_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
